// File: rtl/mpu_ctx_sched_pkg.sv
// mpu_ctx_sched_pkg: region word, CSR layout and op encodings shared by the MPU.
// Imported by mpu_ctx_sched and mpu_ep_lifo.
package mpu_ctx_sched_pkg;

    localparam int MAPS    = 9;
    localparam int ROWS    = 4;
    localparam int DEPTH   = 8;
    localparam int ROW_W   = $clog2(ROWS);
    localparam int DEPTH_W = $clog2(DEPTH + 1);

    typedef logic [11:0] CsrAddrT;

    localparam CsrAddrT CsrBase = 12'h400;

    typedef struct packed {
        logic [13:0] addr;
        logic [15:0] length;
        logic        write_en;
        logic        read_en;
    } mpu_addr_t;

    localparam mpu_addr_t NO_ACCESS = '0;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } mpu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        READY
    } sched_state_e;

    function automatic CsrAddrT csr_addr(
        input logic [3:0]       map,
        input logic [ROW_W-1:0] row
    );
        return CsrBase + CsrAddrT'(row) + CsrAddrT'(ROWS) * CsrAddrT'(map);
    endfunction

endpackage

// File: rtl/mpu_ep_lifo.sv
// mpu_ep_lifo: DEPTH x 16 entry-pointer stack for nested preemptions.
// Push at full and pop at empty leave the stack untouched and flag it.
module mpu_ep_lifo
    import mpu_ctx_sched_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [15:0]        din,
    output logic [15:0]        top,
    output logic [DEPTH_W-1:0] depth,
    output logic               overflow,
    output logic               underflow
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [15:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] rd_idx;
    logic              full;
    logic              empty;

    assign full      = depth == DEPTH_W'(DEPTH);
    assign empty     = depth == '0;
    assign overflow  = push && full;
    assign underflow = pop && empty;

    // At full the low bits wrap to 0, so rd_idx still lands on the last slot.
    assign wr_idx = depth[ADDR_W-1:0];
    assign rd_idx = wr_idx - 1'b1;
    assign top    = empty ? '0 : mem[rd_idx];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            depth <= '0;
        end else if (push && !full) begin
            depth <= depth + 1'b1;
        end else if (pop && !empty) begin
            depth <= depth - 1'b1;
        end
    end

endmodule

// File: rtl/mpu_ctx_sched.sv
// mpu_ctx_sched: reloads the MPU active region map and ep on every context change.
// Define MPU_NEST_FAULT_EN to pulse nest_fault on ep LIFO overflow/underflow.
module mpu_ctx_sched
    import mpu_ctx_sched_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         interrupt_prio,
    input  logic [3:0]         id,
    input  logic [15:0]        sp,
    output logic [11:0]        cfg_rd_addr,
    output logic               cfg_rd_en,
    input  logic [31:0]        cfg_rd_data,
    output logic               region_we,
    output logic [ROW_W-1:0]   region_idx,
    output logic [31:0]        region_data,
    output logic [15:0]        ep,
    output logic [DEPTH_W-1:0] depth,
    output logic               stall,
    output logic               ctx_ready,
    output logic               nest_fault
);

    sched_state_e     state;
    logic [7:0]       last_prio;
    logic [3:0]       last_id;
    logic [3:0]       new_id;
    logic             primed;
    logic             change;
    logic             push;
    logic             pop;
    logic             map_bad;
    logic             map_zero;
    logic             pend_zero;
    logic             issuing;
    logic [ROW_W-1:0] row;
    logic             ready_q;
    logic [15:0]      lifo_top;
    logic             overflow;
    logic             underflow;
    logic             fault;

    assign change  = !primed || interrupt_prio != last_prio || id != last_id;
    assign push    = reset && change && interrupt_prio > last_prio;
    assign pop     = reset && change && interrupt_prio < last_prio;
    assign map_bad = id >= 4'(MAPS);

    assign stall       = reset && (change || !ready_q);
    assign ctx_ready   = reset && ready_q && !change;
    assign region_data = (region_we && !pend_zero) ? cfg_rd_data : NO_ACCESS;

`ifdef MPU_NEST_FAULT_EN
    assign fault = overflow || underflow;
`else
    logic unused_nest;
    assign unused_nest = overflow;
    assign fault       = 1'b0;
`endif

    mpu_ep_lifo u_lifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .din       (ep),
        .top       (lifo_top),
        .depth     (depth),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            last_prio   <= '0;
            last_id     <= '0;
            new_id      <= '0;
            primed      <= 1'b0;
            map_zero    <= 1'b0;
            pend_zero   <= 1'b0;
            issuing     <= 1'b0;
            row         <= '0;
            ready_q     <= 1'b0;
            ep          <= '0;
            cfg_rd_en   <= 1'b0;
            cfg_rd_addr <= '0;
            region_we   <= 1'b0;
            region_idx  <= '0;
            nest_fault  <= 1'b0;
        end else begin
            // Read data lands one cycle after the read, so writes trail reads.
            region_we  <= issuing;
            region_idx <= row;
            pend_zero  <= map_zero;
            nest_fault <= fault;

            if (push) begin
                ep <= sp;
            end else if (pop && !underflow) begin
                ep <= lifo_top;
            end

            if (change) begin
                primed      <= 1'b1;
                last_prio   <= interrupt_prio;
                last_id     <= id;
                new_id      <= id;
                map_zero    <= map_bad;
                state       <= FETCH;
                issuing     <= 1'b1;
                row         <= '0;
                region_we   <= 1'b0;
                ready_q     <= 1'b0;
                cfg_rd_en   <= !map_bad;
                cfg_rd_addr <= csr_addr(id, ROW_W'(0));
            end else begin
                unique case (state)
                    FETCH: begin
                        if (issuing) begin
                            if (row == ROW_W'(ROWS - 1)) begin
                                issuing   <= 1'b0;
                                cfg_rd_en <= 1'b0;
                            end else begin
                                row         <= row + 1'b1;
                                cfg_rd_addr <= csr_addr(new_id, row + 1'b1);
                            end
                        end
                        if (region_we && region_idx == ROW_W'(ROWS - 1)) begin
                            state   <= READY;
                            ready_q <= 1'b1;
                        end
                    end
                    IDLE, READY: begin
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/mpu_ctx_sched.md
# mpu_ctx_sched

Context scheduler for the memory protection unit. It watches the interrupt priority and task id from the interrupt controller and keeps a LIFO of entry pointers (ep) across nested preemptions. On every context change it reads the new task's region rows from the MPU CSR bank, one row per cycle, and writes them into the MPU's active region registers. It holds the core's load/store stage stalled until the active map and ep match the running context.

## Interface
- Maps, 9: number of per-context region maps (8 interrupts + 1 memory exception).
- Rows, 4: regions per map.
- Depth, 8: maximum nesting depth of the ep LIFO.
- CsrBase, 'h400: CSR address of map 0, row 0; row r of map k is at CsrBase + r + Rows*k.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-low reset.
- interrupt_prio  in  8  priority of the running context.
- id  in  4  map index of the running context (0..Maps-1).
- sp  in  16  current stack pointer.
- cfg_rd_addr  out  12  CSR address read from the region CSR bank.
- cfg_rd_en  out  1  read strobe.
- cfg_rd_data  in  32  CSR word, valid one cycle after cfg_rd_en.
- region_we  out  1  write strobe to the MPU active-map row.
- region_idx  out  $clog2(Rows)  row being written.
- region_data  out  32  packed {addr[13:0], length[15:0], write_en, read_en}, MSB first.
- ep  out  16  entry pointer of the current context.
- depth  out  $clog2(Depth+1)  current nesting depth.
- stall  out  1  high while the active map or ep is stale.
- ctx_ready  out  1  high when the map is loaded for the sampled {prio, id}.
- nest_fault  out  1  one-cycle pulse on LIFO overflow or underflow (see Configuration).

## Operation
Reset (reset low):
- All outputs 0; state IDLE.
- last_prio and last_id cleared; `primed` flag cleared.

Change detect:
- Each cycle, compare {interrupt_prio, id} with {last_prio, last_id}.
- A difference, or `primed` = 0, is a context change. Latch new_id, set `primed`, update last_*.

Ep stack, applied in the change-detect cycle:
- prio > last_prio (push): lifo[depth] <= ep; ep <= sp; depth++.
- prio < last_prio (pop): depth--; ep <= lifo[depth-1].
- Equal prio (id-only change): reload the map only; ep is unchanged.

FSM:
- IDLE: on a change, go to FETCH.
- FETCH: issue cfg_rd_en with address CsrBase + row + Rows*new_id, row 0..Rows-1, one per cycle.
  - Each returned word is written one cycle later via region_we / region_idx = row.
  - After the last write, go to READY.
- READY: ctx_ready = 1, stall = 0. On a change, go to FETCH and restart at row 0.
- A change during FETCH aborts the walk. Reads already in flight are discarded: no region_we for them. The walk restarts at row 0 with the new id the next cycle.
- id >= Maps: no reads are issued. All rows are written with 0 (no access), then READY.

## Timing
- Change seen at cycle T: stall is high combinationally in T.
- First read in T+1; last write in T+Rows+1; ctx_ready = 1 and stall = 0 from T+Rows+2. Latency is Rows+2 cycles.
- ep is valid from T+1.
- Pending writes are the ones already issued when a reset or restart hits.
- Reset mid-walk: no pending writes complete; outputs are 0 on the next edge.
- Out of reset, the first load takes the {prio, id} sampled in the first cycle with reset high.

## Configuration
- MPU_NEST_FAULT_EN defined:
  - Push at depth == Depth: LIFO and depth unchanged, ep still <= sp.
  - Pop at depth == 0: ep unchanged.
  - Both pulse nest_fault for one cycle.
- Undefined: depth saturates silently in both cases, and nest_fault is tied to 0.

## Structure
- Shared mpu package holds mpu_addr_t (the packed region word), CsrAddrT, CsrBase, and the OP_LOAD/OP_STORE encodings. The MPU and this block both import it.
- One sub-module, mpu_ep_lifo: Depth x 16 register stack with push, pop, depth, overflow and underflow outputs.
- The FSM and row counter stay in mpu_ctx_sched.

## Test plan
- Reset release with prio=0, id=0, CSRs 'h400..'h403 preloaded: 4 writes, region_idx 0..3 carry the CSR words; ctx_ready and stall=0 at cycle 6.
- prio 0→5, id 3, sp='h2F00: reads start at 'h40C; ep='h2F00, depth=1; after the return to prio 0, ep is restored to the previous value and depth=0.
- Id change 3→4 in row 2 of a walk: no write carries map-3 row 2/3 data; rows 0..3 end with map-4 ('h410..'h413) data.
- Nine nested pushes with Depth=8 and MPU_NEST_FAULT_EN: the ninth push pulses nest_fault, depth stays 8; pop at depth 0 pulses nest_fault, ep is unchanged.
- id=12 with Maps=9: cfg_rd_en never asserts; 4 zero writes; ctx_ready after Rows+2 cycles.
- reset driven low in the middle of FETCH: next cycle all outputs are 0 and there are no further region_we.
